// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: default widths,
// port-select encoding and the conflict counter helper.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;
    localparam int CONFLICT_W = 16;

    // Which requester owns an access; also the MSB of the RAM address.
    typedef enum logic {
        PORT_IR   = 1'b0,
        PORT_MAIN = 1'b1
    } port_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CONFLICT_W-1:0] sat_inc(input logic [CONFLICT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter. Grants are combinational; the only state is
// the winner of the last contended cycle, which decides the next contention.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic req_ir,
    input  logic req_main,
    output logic grant_ir,
    output logic grant_main
);

    port_e last_winner;

    // Lone requester wins outright; on contention the previous loser wins.
    always_comb begin
        grant_ir   = 1'b0;
        grant_main = 1'b0;
        if (!reset) begin
            if (req_ir && req_main) begin
                if (last_winner == PORT_MAIN) begin
                    grant_ir = 1'b1;
                end else begin
                    grant_main = 1'b1;
                end
            end else begin
                grant_ir   = req_ir;
                grant_main = req_main;
            end
        end
    end

    // Remember the contended winner; reset pretends main won last so ir goes first.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_winner <= PORT_MAIN;
        end else if (req_ir && req_main) begin
            last_winner <= grant_ir ? PORT_IR : PORT_MAIN;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction port and a data port onto one single-port RAM.
// The ir port maps to the lower half of the RAM, main to the upper half.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ir_req,
    input  logic                  ir_rw,
    input  logic [ADDR_W-1:0]     ir_addr,
    input  logic [DATA_W-1:0]     ir_wdata,
    input  logic                  main_req,
    input  logic                  main_rw,
    input  logic [ADDR_W-1:0]     main_addr,
    input  logic [DATA_W-1:0]     main_wdata,
    output logic                  ir_ack,
    output logic                  main_ack,
    output logic                  ir_rvalid,
    output logic                  main_rvalid,
    output logic [DATA_W-1:0]     ir_rdata,
    output logic [DATA_W-1:0]     main_rdata,
    output logic [ADDR_W:0]       ram_addr,
    output logic [DATA_W-1:0]     ram_data,
    output logic                  ram_wren,
    input  logic [DATA_W-1:0]     ram_q,
    output logic [CONFLICT_W-1:0] conflicts
);

    logic                  grant_ir;
    logic                  grant_main;
    logic                  any_grant;
    logic [ADDR_W:0]       issue_addr;
    logic [DATA_W-1:0]     issue_data;
    logic                  issue_wren;
    logic [ADDR_W:0]       ram_addr_q;
    logic [DATA_W-1:0]     ram_data_q;
    logic                  rd_pending;
    port_e                 rd_owner;
    logic [DATA_W-1:0]     ir_rdata_q;
    logic [DATA_W-1:0]     main_rdata_q;
    logic [CONFLICT_W-1:0] conflicts_q;

    rr_arb2 u_rr_arb2 (
        .clock      (clock),
        .reset      (reset),
        .req_ir     (ir_req),
        .req_main   (main_req),
        .grant_ir   (grant_ir),
        .grant_main (grant_main)
    );

    assign any_grant = grant_ir | grant_main;

    // Steer the granted port onto the RAM bus; with no grant the bus keeps its last address/data.
    always_comb begin
        issue_addr = ram_addr_q;
        issue_data = ram_data_q;
        issue_wren = 1'b0;
        if (grant_ir) begin
            issue_addr = {PORT_IR, ir_addr};
            issue_data = ir_wdata;
            issue_wren = ir_rw;
        end else if (grant_main) begin
            issue_addr = {PORT_MAIN, main_addr};
            issue_data = main_wdata;
            issue_wren = main_rw;
        end
    end

    assign ir_ack      = grant_ir;
    assign main_ack    = grant_main;
    assign ram_addr    = issue_addr;
    assign ram_data    = issue_data;
    assign ram_wren    = issue_wren;
    assign ir_rvalid   = rd_pending && (rd_owner == PORT_IR);
    assign main_rvalid = rd_pending && (rd_owner == PORT_MAIN);
    assign ir_rdata    = ir_rvalid ? ram_q : ir_rdata_q;
    assign main_rdata  = main_rvalid ? ram_q : main_rdata_q;
    assign conflicts   = conflicts_q;

    // Bus hold registers, outstanding-read tracking, read-data hold and conflict count.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            rd_pending   <= 1'b0;
            rd_owner     <= PORT_IR;
            ir_rdata_q   <= '0;
            main_rdata_q <= '0;
            conflicts_q  <= '0;
        end else begin
            rd_pending <= any_grant && !issue_wren;
            if (any_grant) begin
                ram_addr_q <= issue_addr;
                ram_data_q <= issue_data;
                rd_owner   <= grant_main ? PORT_MAIN : PORT_IR;
            end
            if (ir_rvalid) begin
                ir_rdata_q <= ram_q;
            end
            if (main_rvalid) begin
                main_rdata_q <= ram_q;
            end
            if (ir_req && main_req) begin
                conflicts_q <= sat_inc(conflicts_q);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural synchronous RAM.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        ir_req, ir_rw, main_req, main_rw;
    logic [11:0] ir_addr, main_addr;
    logic [15:0] ir_wdata, main_wdata;
    logic        ir_ack, main_ack, ir_rvalid, main_rvalid;
    logic [15:0] ir_rdata, main_rdata;
    logic [12:0] ram_addr;
    logic [15:0] ram_data;
    logic        ram_wren;
    logic [15:0] ram_q = 16'h0000;
    logic [15:0] conflicts;
    logic [15:0] mem [0:8191];

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(12), .DATA_W(16)) dut (
        .clock       (clock),
        .reset       (reset),
        .ir_req      (ir_req),
        .ir_rw       (ir_rw),
        .ir_addr     (ir_addr),
        .ir_wdata    (ir_wdata),
        .main_req    (main_req),
        .main_rw     (main_rw),
        .main_addr   (main_addr),
        .main_wdata  (main_wdata),
        .ir_ack      (ir_ack),
        .main_ack    (main_ack),
        .ir_rvalid   (ir_rvalid),
        .main_rvalid (main_rvalid),
        .ir_rdata    (ir_rdata),
        .main_rdata  (main_rdata),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q),
        .conflicts   (conflicts)
    );

    always #5 clock = ~clock;

    // Single-port RAM: read data appears one edge after the address.
    always @(posedge clock) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ir_ack"}, {31'd0, ir_ack}, 32'd0);
        check({tag, " main_ack"}, {31'd0, main_ack}, 32'd0);
        check({tag, " ir_rvalid"}, {31'd0, ir_rvalid}, 32'd0);
        check({tag, " main_rvalid"}, {31'd0, main_rvalid}, 32'd0);
        check({tag, " ir_rdata"}, {16'd0, ir_rdata}, 32'd0);
        check({tag, " main_rdata"}, {16'd0, main_rdata}, 32'd0);
        check({tag, " ram_wren"}, {31'd0, ram_wren}, 32'd0);
        check({tag, " ram_addr"}, {19'd0, ram_addr}, 32'd0);
        check({tag, " ram_data"}, {16'd0, ram_data}, 32'd0);
        check({tag, " conflicts"}, {16'd0, conflicts}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
        mem[13'h0005] = 16'hABCD;
        reset = 1'b1;
        ir_req = 1'b0; ir_rw = 1'b0; ir_addr = '0; ir_wdata = '0;
        main_req = 1'b0; main_rw = 1'b0; main_addr = '0; main_wdata = '0;

        // Reset state
        tick();
        check_all_zero("reset");
        reset = 1'b0;

        // Lone ir read at 12'h005
        ir_req = 1'b1; ir_rw = 1'b0; ir_addr = 12'h005;
        #1;
        check("ir_rd ack", {31'd0, ir_ack}, 32'd1);
        check("ir_rd main_ack", {31'd0, main_ack}, 32'd0);
        check("ir_rd ram_addr", {19'd0, ram_addr}, 32'h0005);
        check("ir_rd ram_wren", {31'd0, ram_wren}, 32'd0);
        tick();
        ir_req = 1'b0;
        #1;
        check("ir_rd rvalid", {31'd0, ir_rvalid}, 32'd1);
        check("ir_rd rdata", {16'd0, ir_rdata}, 32'hABCD);
        check("ir_rd main_rvalid", {31'd0, main_rvalid}, 32'd0);

        // Idle cycle: bus holds address, nothing issued, rdata held
        tick();
        check("idle ir_ack", {31'd0, ir_ack}, 32'd0);
        check("idle ram_wren", {31'd0, ram_wren}, 32'd0);
        check("idle ram_addr", {19'd0, ram_addr}, 32'h0005);
        check("idle ir_rvalid", {31'd0, ir_rvalid}, 32'd0);
        check("idle ir_rdata hold", {16'd0, ir_rdata}, 32'hABCD);

        // main write then read back at 12'h010
        main_req = 1'b1; main_rw = 1'b1; main_addr = 12'h010; main_wdata = 16'h1234;
        #1;
        check("main_wr ack", {31'd0, main_ack}, 32'd1);
        check("main_wr ram_addr", {19'd0, ram_addr}, 32'h1010);
        check("main_wr ram_wren", {31'd0, ram_wren}, 32'd1);
        check("main_wr ram_data", {16'd0, ram_data}, 32'h1234);
        tick();
        main_rw = 1'b0;
        #1;
        check("main_rd ack", {31'd0, main_ack}, 32'd1);
        check("main_rd ram_wren", {31'd0, ram_wren}, 32'd0);
        check("main_rd ram_addr", {19'd0, ram_addr}, 32'h1010);
        check("main_wr no rvalid", {31'd0, main_rvalid}, 32'd0);
        tick();
        main_req = 1'b0;
        #1;
        check("main_rd rvalid", {31'd0, main_rvalid}, 32'd1);
        check("main_rd rdata", {16'd0, main_rdata}, 32'h1234);
        check("main_rd ir_rvalid", {31'd0, ir_rvalid}, 32'd0);

        // Continuous contention for 4 cycles after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ir_req = 1'b1; ir_rw = 1'b0; ir_addr = 12'h005;
        main_req = 1'b1; main_rw = 1'b0; main_addr = 12'h010;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rr%0d ir_ack", k), {31'd0, ir_ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d main_ack", k), {31'd0, main_ack}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d ir_rvalid", k), {31'd0, ir_rvalid}, (k % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("rr%0d main_rvalid", k), {31'd0, main_rvalid}, (k > 0 && k % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        ir_req = 1'b0; main_req = 1'b0;
        #1;
        check("rr4 main_rvalid", {31'd0, main_rvalid}, 32'd1);
        check("rr4 main_rdata", {16'd0, main_rdata}, 32'h1234);
        check("rr4 ir_rdata", {16'd0, ir_rdata}, 32'hABCD);
        check("rr4 conflicts", {16'd0, conflicts}, 32'd4);

        // Reset with an ir read outstanding; priority returns to ir
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ir_req = 1'b1; main_req = 1'b1;
        #1;
        check("rst_rd first contention ir", {31'd0, ir_ack}, 32'd1);
        tick();
        main_req = 1'b0;
        #1;
        check("rst_rd ir alone ack", {31'd0, ir_ack}, 32'd1);
        tick();
        reset = 1'b1; ir_req = 1'b0;
        #1;
        check("rst_rd in-flight rvalid", {31'd0, ir_rvalid}, 32'd1);
        tick();
        reset = 1'b0;
        #1;
        check_all_zero("rst_rd");
        tick();
        check("rst_rd no late rvalid", {31'd0, ir_rvalid}, 32'd0);
        ir_req = 1'b1; main_req = 1'b1;
        #1;
        check("rst_rd ir favoured", {31'd0, ir_ack}, 32'd1);
        check("rst_rd main loses", {31'd0, main_ack}, 32'd0);
        tick();
        ir_req = 1'b0; main_req = 1'b0;

        // Conflict counter saturation
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ir_req = 1'b1; main_req = 1'b1;
        repeat (65534) tick();
        check("sat FFFE", {16'd0, conflicts}, 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("sat hold%0d", i), {16'd0, conflicts}, 32'hFFFF);
        end
        ir_req = 1'b0; main_req = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
